// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the parametrised synchronous FIFO:
//   - fifo_mode_e : output-stage mode (registered read or first-word-fall-through)
//   - default parameter values
//   - width helpers for pointers and the occupancy counter
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  typedef enum logic {
    MODE_STD  = 1'b0,  // data_o registered, updates the cycle after a read
    MODE_FWFT = 1'b1   // data_o shows the head entry combinationally
  } fifo_mode_e;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AE_THRESH = 2;

  // Pointer width: indexes DEPTH entries and wraps naturally.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Counter width: one extra bit so the value DEPTH is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Simple dual-port storage array, DEPTH x DATA_W.
// Ports:
//   clk   : clock, write on rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : read data, follows raddr combinationally
// -----------------------------------------------------------------------------
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose; validity is tracked by the
  // pointers and count, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised synchronous FIFO with selectable output stage (registered read
// or first-word-fall-through), occupancy count, almost-full/almost-empty
// flags, overflow/underflow pulses and a synchronous flush.
// Ports:
//   clk            : clock, all logic on rising edge
//   rst            : synchronous reset, active-high
//   clear_i        : synchronous flush, overrides we_i/re_i
//   we_i, data_i   : write request and data
//   re_i           : read request
//   data_o         : read data (registered or FWFT head)
//   full_o/empty_o : count == DEPTH / count == 0
//   almost_full_o  : count >= AF_THRESH
//   almost_empty_o : count <= AE_THRESH
//   count_o        : occupancy 0..DEPTH
//   overflow_o     : one-cycle pulse after a rejected write
//   underflow_o    : one-cycle pulse after a rejected read
// -----------------------------------------------------------------------------
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   we_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic                   re_i,
  output logic [DATA_W-1:0]      data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int         PW   = ptr_w(DEPTH);
  localparam int         CW   = cnt_w(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? MODE_FWFT : MODE_STD;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must be in 0..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] head_data;
  logic              overflow_q;
  logic              underflow_q;
  logic              empty;
  logic              full;
  logic              rd_acc;
  logic              wr_acc;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A read at full frees a slot in the same edge, so the write may proceed.
  assign rd_acc = re_i && !empty;
  assign wr_acc = we_i && (!full || rd_acc);

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !clear_i && !rst),
    .waddr (wr_ptr_q),
    .wdata (data_i),
    .raddr (rd_ptr_q),
    .rdata (head_data)
  );

  // data_q is the output register in MODE_STD. In MODE_FWFT it tracks the
  // current head so data_o can keep showing the last head while empty.
  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PW'(1);

      unique case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      overflow_q  <= we_i && !wr_acc;
      underflow_q <= re_i && !rd_acc;

      if (MODE == MODE_STD) begin
        if (rd_acc) data_q <= head_data;
      end else begin
        if (!empty) data_q <= head_data;
      end
    end
  end

  assign data_o         = (MODE == MODE_FWFT && !empty) ? head_data : data_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= AF_CNT);
  assign almost_empty_o = (count_q <= AE_CNT);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Drives one registered-read FIFO and one FWFT FIFO with identical stimulus
// and compares both against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int AF_T   = DEPTH - 2;
  localparam int AE_T   = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] din;

  logic [DATA_W-1:0] s_data, f_data;
  logic              s_full, f_full, s_empty, f_empty;
  logic              s_af, f_af, s_ae, f_ae, s_ov, f_ov, s_un, f_un;
  logic [CW-1:0]     s_count, f_count;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clear_i(clear), .we_i(we), .data_i(din), .re_i(re),
    .data_o(s_data), .full_o(s_full), .empty_o(s_empty),
    .almost_full_o(s_af), .almost_empty_o(s_ae), .count_o(s_count),
    .overflow_o(s_ov), .underflow_o(s_un)
  );

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .clear_i(clear), .we_i(we), .data_i(din), .re_i(re),
    .data_o(f_data), .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_count),
    .overflow_o(f_ov), .underflow_o(f_un)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents as a queue, plus the expected output values.
  logic [DATA_W-1:0] model_q [$];
  logic [DATA_W-1:0] exp_std_data;
  logic [DATA_W-1:0] exp_fwft_last;
  logic              exp_ov;
  logic              exp_un;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_update(input logic w, input logic r, input logic c,
                              input logic rs, input logic [DATA_W-1:0] d);
    bit rd_ok, wr_ok;
    if (rs || c) begin
      model_q.delete();
      exp_std_data  = '0;
      exp_fwft_last = '0;
      exp_ov        = 1'b0;
      exp_un        = 1'b0;
    end else begin
      rd_ok = r && (model_q.size() > 0);
      wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
      if (rd_ok) exp_std_data = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
      exp_ov = w && !wr_ok;
      exp_un = r && !rd_ok;
    end
  endtask

  task automatic compare_all();
    int n;
    logic [DATA_W-1:0] exp_fwft_data;
    n = model_q.size();
    exp_fwft_data = (n > 0) ? model_q[0] : exp_fwft_last;
    check("std_count", 64'(s_count), 64'(n));
    check("fwft_count", 64'(f_count), 64'(n));
    check("std_empty", 64'(s_empty), 64'(n == 0));
    check("fwft_empty", 64'(f_empty), 64'(n == 0));
    check("std_full", 64'(s_full), 64'(n == DEPTH));
    check("fwft_full", 64'(f_full), 64'(n == DEPTH));
    check("std_afull", 64'(s_af), 64'(n >= AF_T));
    check("fwft_afull", 64'(f_af), 64'(n >= AF_T));
    check("std_aempty", 64'(s_ae), 64'(n <= AE_T));
    check("fwft_aempty", 64'(f_ae), 64'(n <= AE_T));
    check("std_ovf", 64'(s_ov), 64'(exp_ov));
    check("fwft_ovf", 64'(f_ov), 64'(exp_ov));
    check("std_unf", 64'(s_un), 64'(exp_un));
    check("fwft_unf", 64'(f_un), 64'(exp_un));
    check("std_data", 64'(s_data), 64'(exp_std_data));
    check("fwft_data", 64'(f_data), 64'(exp_fwft_data));
    // The head shown now is what an FWFT output holds once the queue drains.
    if (n > 0) exp_fwft_last = model_q[0];
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic step(input logic w, input logic r, input logic c,
                      input logic rs, input logic [DATA_W-1:0] d);
    we = w; re = r; clear = c; rst = rs; din = d;
    @(posedge clk);
    model_update(w, r, c, rs, d);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; we = 1'b0; re = 1'b0; din = '0;
    exp_std_data = '0; exp_fwft_last = '0; exp_ov = 1'b0; exp_un = 1'b0;

    // Reset state.
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 1, '0);
    check("rst_empty", 64'(s_empty), 64'(1));
    check("rst_data", 64'(s_data), 64'(0));

    // Fill 0x1..0x10; almost_full after the 14th, full after the 16th.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, 0, 0, DATA_W'(i));
      if (i == 13) check("t1_af_13", 64'(s_af), 64'(0));
      if (i == 14) check("t1_af_14", 64'(s_af), 64'(1));
    end
    check("t1_full", 64'(s_full), 64'(1));
    check("t1_count16", 64'(s_count), 64'(16));
    step(1, 0, 0, 0, 32'hFF);
    check("t1_ovf_pulse", 64'(s_ov), 64'(1));
    step(0, 0, 0, 0, '0);
    check("t1_ovf_drop", 64'(s_ov), 64'(0));

    // Drain with 17 reads; the last is rejected and data_o holds 0x10.
    for (int i = 1; i <= DEPTH + 1; i++) begin
      step(0, 1, 0, 0, '0);
      if (i <= DEPTH) check("t2_seq", 64'(s_data), 64'(i));
    end
    check("t2_unf", 64'(s_un), 64'(1));
    check("t2_hold", 64'(s_data), 64'(32'h10));

    // FWFT: a write into empty shows on data_o next cycle without a read.
    step(1, 0, 0, 0, 32'hA5A5A5A5);
    check("t3_fwft_show", 64'(f_data), 64'(32'hA5A5A5A5));
    step(0, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    check("t3_fwft_empty", 64'(f_empty), 64'(1));

    // Simultaneous read/write at full, then at empty.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, DATA_W'(32'h100 + i));
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, DATA_W'(32'h200 + i));
      check("t4_full_cnt", 64'(s_count), 64'(16));
    end
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, '0);
    step(1, 1, 0, 0, 32'h300);
    check("t4_empty_unf", 64'(s_un), 64'(1));
    check("t4_empty_cnt", 64'(s_count), 64'(1));
    step(0, 1, 0, 0, '0);

    // Wrap: hold occupancy at 3 across many pointer wraps.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, DATA_W'(32'h400 + i));
    for (int i = 3; i < 43; i++) step(1, 1, 0, 0, DATA_W'(32'h400 + i));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);

    // Flush at count 5 with a concurrent write: write dropped, no overflow.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, DATA_W'(32'h500 + i));
    step(1, 0, 1, 0, 32'h5FF);
    check("t6_clr_cnt", 64'(s_count), 64'(0));
    check("t6_clr_ovf", 64'(s_ov), 64'(0));
    check("t6_clr_data", 64'(s_data), 64'(0));
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, DATA_W'(32'h600 + i));
    step(1, 1, 0, 0, 32'h6FF);
    step(1, 0, 0, 1, 32'h6EE);
    check("t6_rst_cnt", 64'(s_count), 64'(0));
    check("t6_rst_data", 64'(s_data), 64'(0));

    // Random traffic with shifting write/read bias, rare flush and reset.
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      wp = ((i / 300) % 2 == 0) ? 70 : 30;
      rp = 100 - wp;
      step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
           ($urandom_range(0, 79) == 0), ($urandom_range(0, 299) == 0),
           DATA_W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
